// File: rtl/alu_accum_param.sv
// Accumulating ALU with registered flags and a multi-cycle shift-add multiplier.
// Single-cycle ops complete on the accepting edge; MUL holds oReady low for WIDTH edges.
module alu_accum_param #(
  parameter int WIDTH = 16
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic             iValid,
  output logic             oReady,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [3:0]       iOpcode,
  output logic [WIDTH-1:0] oAccumulator,
  output logic             oValid,
  output logic             oCarry,
  output logic             oZero,
  output logic             oNegative,
  output logic             oOverflow
);

  typedef enum logic {IDLE, MUL} state_t;

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [3:0] OP_MUL = 4'b1100;

  state_t             state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] product_next;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res;
  logic               res_c;
  logic               res_v;
  logic               write;
  logic               accept;

  assign oReady       = (state == IDLE);
  assign accept       = iValid && oReady;
  assign product_next = product + (mplier[0] ? mcand : '0);

  // Result and flags of the single-cycle opcodes; write=0 means leave registers alone.
  always_comb begin
    sum   = '0;
    res   = oAccumulator;
    res_c = oCarry;
    res_v = oOverflow;
    write = 1'b1;
    case (iOpcode)
      4'b0000: begin res = iA & iB; res_c = 1'b0; res_v = 1'b0; end
      4'b0001: begin res = iA | iB; res_c = 1'b0; res_v = 1'b0; end
      4'b0010: begin res = iA ^ iB; res_c = 1'b0; res_v = 1'b0; end
      4'b0011: begin res = ~iA;     res_c = 1'b0; res_v = 1'b0; end
      4'b0100: begin res = iB;      res_c = 1'b0; res_v = 1'b0; end
      4'b1000, 4'b1010: begin
        sum   = {1'b0, iA} + {1'b0, iB}
                + {{WIDTH{1'b0}}, (iOpcode == 4'b1010) ? oCarry : 1'b0};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (iA[WIDTH-1] == iB[WIDTH-1]) && (res[WIDTH-1] != iA[WIDTH-1]);
      end
      4'b1001: begin
        // Bit WIDTH of the extended difference is the unsigned borrow.
        sum   = {1'b0, iA} - {1'b0, iB};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (iA[WIDTH-1] != iB[WIDTH-1]) && (res[WIDTH-1] != iA[WIDTH-1]);
      end
      4'b1011: begin
        sum   = {1'b0, oAccumulator} + {1'b0, iA};
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = (oAccumulator[WIDTH-1] == iA[WIDTH-1]) &&
                (res[WIDTH-1] != oAccumulator[WIDTH-1]);
      end
      default: write = 1'b0;
    endcase
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state        <= IDLE;
      count        <= '0;
      mcand        <= '0;
      mplier       <= '0;
      product      <= '0;
      oAccumulator <= '0;
      oCarry       <= 1'b0;
      oZero        <= 1'b1;
      oNegative    <= 1'b0;
      oOverflow    <= 1'b0;
      oValid       <= 1'b0;
    end else begin
      oValid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (iOpcode == OP_MUL) begin
              state   <= MUL;
              count   <= '0;
              mcand   <= {{WIDTH{1'b0}}, iA};
              mplier  <= iB;
              product <= '0;
            end else begin
              oValid <= 1'b1;
              if (write) begin
                oAccumulator <= res;
                oCarry       <= res_c;
                oZero        <= (res == '0);
                oNegative    <= res[WIDTH-1];
                oOverflow    <= res_v;
              end
            end
          end
        end
        MUL: begin
          // One multiplier bit per edge; the WIDTH-th edge commits the product.
          product <= product_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          count   <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state        <= IDLE;
            count        <= '0;
            oValid       <= 1'b1;
            oAccumulator <= product_next[WIDTH-1:0];
            oCarry       <= |product_next[2*WIDTH-1:WIDTH];
            oZero        <= (product_next[WIDTH-1:0] == '0);
            oNegative    <= product_next[WIDTH-1];
            oOverflow    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/alu_accum_param.md
ALU_ACCUM_PARAM -- requirements
Module: alu_accum_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning datapath width in bits; legal range 4..64.
REQ-002 The block SHALL have port iClock  input  1  sole clock; all state changes on its rising edge.
REQ-003 The block SHALL have port iReset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port iValid  input  1  operation request, qualified by oReady.
REQ-005 The block SHALL have port oReady  output  1  high when a new operation can be accepted.
REQ-006 The block SHALL have port iA  input  WIDTH  operand A.
REQ-007 The block SHALL have port iB  input  WIDTH  operand B.
REQ-008 The block SHALL have port iOpcode  input  4  operation select.
REQ-009 The block SHALL have port oAccumulator  output  WIDTH  registered result.
REQ-010 The block SHALL have port oValid  output  1  one-cycle pulse when a result is written.
REQ-011 The block SHALL have port oCarry  output  1  registered carry/borrow flag.
REQ-012 The block SHALL have port oZero  output  1  registered zero flag.
REQ-013 The block SHALL have port oNegative  output  1  registered MSB-of-result flag.
REQ-014 The block SHALL have port oOverflow  output  1  registered signed-overflow flag.

Function
REQ-015 An operation SHALL be accepted on a rising edge where iValid=1 and oReady=1; operands and opcode are sampled on that edge; iValid while oReady=0 is ignored.
REQ-016 The opcode map SHALL be: 0000 AND, 0001 OR, 0010 XOR, 0011 NOT A, 0100 PASS B, 1000 ADD A+B, 1001 SUB A-B, 1010 ADC A+B+oCarry, 1011 ACC oAccumulator+A, 1100 MUL A*B; all other codes are NOP.
REQ-017 The FSM SHALL have states IDLE and MUL; IDLE->MUL on accepting MUL, MUL->IDLE on the WIDTH-th MUL edge; all other opcodes stay in IDLE.
REQ-018 oReady SHALL be 1 in IDLE and 0 in MUL.
REQ-019 Single-cycle ops SHALL write oAccumulator and flags on the accepting edge, with oValid=1 for the following cycle only; back-to-back accepts every cycle are legal.
REQ-020 MUL SHALL be an unsigned shift-add over WIDTH cycles, one multiplier bit per edge; accept at edge N, result written at edge N+WIDTH, oValid=1 for the cycle after edge N+WIDTH, oReady=1 again from edge N+WIDTH.
REQ-021 MUL SHALL write the low WIDTH bits of the 2*WIDTH product; oCarry=1 iff any upper-half bit is nonzero; oOverflow=0.
REQ-022 ADD/ADC/ACC: oCarry = carry out of bit WIDTH-1; oOverflow = operands' signs equal and result sign differs; all sums modulo 2^WIDTH.
REQ-023 SUB: oCarry = borrow (1 iff A<B unsigned); oOverflow = signs of A and B differ and result sign differs from A.
REQ-024 Logic ops SHALL clear oCarry and oOverflow.
REQ-025 For every written result oZero = (result==0) and oNegative = result[WIDTH-1].
REQ-026 NOP SHALL be accepted, pulse oValid, and leave oAccumulator and all flags unchanged.
REQ-027 ADC and ACC SHALL use the register values current before the accepting edge.
REQ-028 Operand changes during MUL SHALL not affect the in-flight product.

Reset
REQ-029 iReset=1 SHALL immediately force state IDLE, oAccumulator=0, oCarry=0, oZero=1, oNegative=0, oOverflow=0, oValid=0, oReady=1, MUL counter 0.
REQ-030 Reset asserted during MUL SHALL abort it with no result write and no oValid pulse; the first edge after release may accept a new operation.

Verification (WIDTH=16)
REQ-031 ADD A=0xFFFF B=0x0001 -> next cycle acc=0x0000, C=1, Z=1, N=0, V=0, oValid one cycle.
REQ-032 SUB A=0x8000 B=0x0001 -> acc=0x7FFF, C=0, V=1, N=0; then SUB A=0x0001 B=0x0002 -> acc=0xFFFF, C=1, N=1, V=0.
REQ-033 ADD 0xFFFF+0x0001 then ADC A=0x0002 B=0x0003 -> acc=0x0006, C=0; then ACC A=0x0004 -> acc=0x000A.
REQ-034 MUL A=0x0100 B=0x0100 -> oReady low 16 cycles, iValid ADD during that time ignored, then acc=0x0000, C=1, Z=1, single oValid pulse.
REQ-035 MUL A=0x0003 B=0x0005 with iReset pulsed at cycle 8 -> all outputs at reset values, no oValid; next MUL A=0x0003 B=0x0005 completes with acc=0x000F, C=0.
REQ-036 Opcode 0111 after acc=0x1234 -> oValid pulse, acc=0x1234 and flags unchanged.
